// File: rtl/add_vec_pkg.sv
// Shared types and the lane-wise pair adder for the vector add engine.
// The ADD_VEC_SATURATE_EN build passes saturate=1 to lane_add.
package add_vec_pkg;

  localparam int unsigned LINE_W_MAX  = 512;  // widest line lane_add handles
  localparam int unsigned ELEM_W_DEF  = 32;
  localparam int unsigned ADDR_W_DEF  = 42;
  localparam int unsigned LEN_W_DEF   = 16;
  localparam int unsigned MAX_OUT_DEF = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} t_state;

  typedef logic [LEN_W_DEF-1:0]  t_tag;
  typedef logic [LINE_W_MAX-1:0] t_line;

  // Line holds np (a,b) pairs of elem_w bits; each result lane is a+b.
  // Lanes above np*elem_w come back zero.
  function automatic t_line lane_add(input t_line line, input int unsigned elem_w,
                                     input int unsigned np, input bit saturate,
                                     output logic sat);
    t_line mask, a, b, s, res;
    mask = (t_line'(1) << elem_w) - t_line'(1);
    res  = '0;
    sat  = 1'b0;
    for (int unsigned i = 0; i < np; i++) begin
      a = (line >> (2 * i * elem_w)) & mask;
      b = (line >> ((2 * i + 1) * elem_w)) & mask;
      s = a + b;
      if (saturate && ((s >> elem_w) != '0)) begin
        s   = mask;
        sat = 1'b1;
      end
      res = res | ((s & mask) << (i * elem_w));
    end
    return res;
  endfunction

endpackage

// File: rtl/add_vec_engine_if.sv
// Flattened CCI-P-style host channel: read request/response and write request/ack.
interface add_vec_engine_if
  import add_vec_pkg::*;
#(
  parameter int unsigned LINE_W = LINE_W_MAX,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
);

  logic              rd_req_valid;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [LEN_W-1:0]  rd_req_tag;
  logic              rd_almost_full;
  logic              rd_rsp_valid;
  logic [LEN_W-1:0]  rd_rsp_tag;
  logic [LINE_W-1:0] rd_rsp_data;
  logic              wr_req_valid;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [LINE_W-1:0] wr_req_data;
  logic              wr_almost_full;
  logic              wr_rsp_valid;

  modport master (
    output rd_req_valid, rd_req_addr, rd_req_tag,
    input  rd_almost_full, rd_rsp_valid, rd_rsp_tag, rd_rsp_data,
    output wr_req_valid, wr_req_addr, wr_req_data,
    input  wr_almost_full, wr_rsp_valid
  );

  modport slave (
    input  rd_req_valid, rd_req_addr, rd_req_tag,
    output rd_almost_full, rd_rsp_valid, rd_rsp_tag, rd_rsp_data,
    input  wr_req_valid, wr_req_addr, wr_req_data,
    output wr_almost_full, wr_rsp_valid
  );

endinterface

// File: rtl/add_vec_result_fifo.sv
// Synchronous FIFO holding summed lines with their tags; push and pop may coincide.
module add_vec_result_fifo
  import add_vec_pkg::*;
#(
  parameter int unsigned DEPTH = MAX_OUT_DEF,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/add_vec_engine.sv
// Streams source lines, adds (a,b) pairs lane-wise, writes one result line per source line.
// Optional ADD_VEC_SATURATE_EN: lanes saturate and a sticky sat_flag port is added.
module add_vec_engine
  import add_vec_pkg::*;
#(
  parameter int unsigned LINE_W          = LINE_W_MAX,
  parameter int unsigned ELEM_W          = ELEM_W_DEF,
  parameter int unsigned ADDR_W          = ADDR_W_DEF,
  parameter int unsigned LEN_W           = LEN_W_DEF,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_src_addr,
  input  logic [ADDR_W-1:0] cfg_dst_addr,
  input  logic [LEN_W-1:0]  cfg_num_lines,
  output logic              busy,
  output logic              done,
  add_vec_engine_if.master  host
`ifdef ADD_VEC_SATURATE_EN
  ,
  output logic              sat_flag
`endif
);

  localparam int unsigned NP     = LINE_W / (2 * ELEM_W);
  localparam int unsigned FIFO_W = LEN_W + LINE_W;
`ifdef ADD_VEC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  t_state state, state_next;

  logic [ADDR_W-1:0] src, dst;
  logic [LEN_W-1:0]  num, issued, popped, acked, inflight;
  logic              active, issue, accept, pop, start;
  logic [LINE_W-1:0] sum_line;
  logic              lane_sat;
  logic [FIFO_W-1:0] fifo_out;
  logic              fifo_empty;
  logic [$clog2(MAX_OUTSTANDING):0] fifo_count;
  logic [LEN_W-1:0]  out_tag;
  logic [LINE_W-1:0] out_line;

  assign active   = (state == RUN) || (state == DRAIN);
  assign start    = (state == IDLE) && cfg_start;
  assign inflight = issued - popped;
  // Credit check on issued-minus-popped keeps the result FIFO from overflowing.
  assign issue    = (state == RUN) && (issued != num)
                    && (inflight < LEN_W'(MAX_OUTSTANDING)) && !host.rd_almost_full;
  assign accept   = active && host.rd_rsp_valid;
  assign pop      = active && !fifo_empty && !host.wr_almost_full;
  assign busy     = active;
  assign out_tag  = fifo_out[FIFO_W-1 -: LEN_W];
  assign out_line = fifo_out[LINE_W-1:0];

  always_comb begin
    sum_line = '0;
    lane_sat = 1'b0;
    sum_line = LINE_W'(lane_add(t_line'(host.rd_rsp_data), ELEM_W, NP, SAT_EN, lane_sat));
  end

  add_vec_result_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (accept),
    .push_data ({host.rd_rsp_tag, sum_line}),
    .pop       (pop),
    .pop_data  (fifo_out),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  logic unused_fifo_count;
  assign unused_fifo_count = ^fifo_count;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cfg_start) state_next = (cfg_num_lines == '0) ? DONE : RUN;
      RUN:     if (issued == num) state_next = DRAIN;
      DRAIN:   if (acked == num) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      src               <= '0;
      dst               <= '0;
      num               <= '0;
      issued            <= '0;
      popped            <= '0;
      acked             <= '0;
      done              <= 1'b0;
      host.rd_req_valid <= 1'b0;
      host.rd_req_addr  <= '0;
      host.rd_req_tag   <= '0;
      host.wr_req_valid <= 1'b0;
      host.wr_req_addr  <= '0;
      host.wr_req_data  <= '0;
    end else begin
      done              <= (state == DONE);
      host.rd_req_valid <= issue;
      host.wr_req_valid <= pop;
      if (start) begin
        src    <= cfg_src_addr;
        dst    <= cfg_dst_addr;
        num    <= cfg_num_lines;
        issued <= '0;
        popped <= '0;
        acked  <= '0;
      end
      if (issue) begin
        host.rd_req_addr <= src + ADDR_W'(issued);
        host.rd_req_tag  <= issued;
        issued           <= issued + 1'b1;
      end
      if (pop) begin
        host.wr_req_addr <= dst + ADDR_W'(out_tag);
        host.wr_req_data <= out_line;
        popped           <= popped + 1'b1;
      end
      if (active && host.wr_rsp_valid) acked <= acked + 1'b1;
    end
  end

`ifdef ADD_VEC_SATURATE_EN
  always_ff @(posedge clk) begin
    if (!reset_n)               sat_flag <= 1'b0;
    else if (start)             sat_flag <= 1'b0;
    else if (accept && lane_sat) sat_flag <= 1'b1;
  end
`else
  logic unused_lane_sat;
  assign unused_lane_sat = lane_sat;
`endif

endmodule

// File: tb/tb_add_vec_engine.sv
// Scoreboard bench for add_vec_engine: expected reads/writes queued at stimulus, checked by a monitor.
module tb_add_vec_engine;
  import add_vec_pkg::*;

  localparam int unsigned LW = 512;
  localparam int unsigned EW = 32;
  localparam int unsigned AW = 42;
  localparam int unsigned TW = 16;
  localparam int unsigned NP = LW / (2 * EW);
`ifdef ADD_VEC_SATURATE_EN
  localparam logic [31:0] OVF_RES = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] OVF_RES = 32'h0000_0001;
`endif

  typedef struct { logic [AW-1:0] addr; logic [LW-1:0] data; } wr_t;
  typedef struct { logic [AW-1:0] addr; logic [TW-1:0] tag;  } rd_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_src_addr = '0;
  logic [AW-1:0] cfg_dst_addr = '0;
  logic [TW-1:0] cfg_num_lines = '0;
  logic          busy, done;
`ifdef ADD_VEC_SATURATE_EN
  logic          sat_flag;
`endif

  add_vec_engine_if #(.LINE_W(LW), .ADDR_W(AW), .LEN_W(TW)) host_if ();

  add_vec_engine #(
    .LINE_W          (LW),
    .ELEM_W          (EW),
    .ADDR_W          (AW),
    .LEN_W           (TW),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cfg_start     (cfg_start),
    .cfg_src_addr  (cfg_src_addr),
    .cfg_dst_addr  (cfg_dst_addr),
    .cfg_num_lines (cfg_num_lines),
    .busy          (busy),
    .done          (done),
    .host          (host_if.master)
`ifdef ADD_VEC_SATURATE_EN
    ,
    .sat_flag      (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int rd_seen = 0, wr_seen = 0, done_seen = 0, acks_sent = 0;
  wr_t wr_exp[$];
  rd_t rd_exp[$];
  logic [AW-1:0] cur_dst = '0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] mk_line(input logic [31:0] a, input logic [31:0] b);
    logic [LW-1:0] l;
    l = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      l[2*i*EW +: EW]     = a;
      l[(2*i+1)*EW +: EW] = b;
    end
    return l;
  endfunction

  function automatic logic [LW-1:0] res_line(input logic [31:0] r);
    logic [LW-1:0] l;
    l = '0;
    for (int unsigned i = 0; i < NP; i++) l[i*EW +: EW] = r;
    return l;
  endfunction

  // Monitor: the only consumer of the expectation queues.
  initial begin
    wr_t we;
    rd_t re;
    forever begin
      @(negedge clk);
      if (host_if.wr_req_valid) begin
        wr_seen++;
        if (wr_exp.size() == 0) chk("wr_unexpected", LW'(1), LW'(0));
        else begin
          we = wr_exp.pop_front();
          chk("wr_addr", LW'(host_if.wr_req_addr), LW'(we.addr));
          chk("wr_data", host_if.wr_req_data, we.data);
        end
      end
      if (host_if.rd_req_valid) begin
        rd_seen++;
        if (rd_exp.size() == 0) chk("rd_unexpected", LW'(1), LW'(0));
        else begin
          re = rd_exp.pop_front();
          chk("rd_tag", LW'(host_if.rd_req_tag), LW'(re.tag));
          chk("rd_addr", LW'(host_if.rd_req_addr), LW'(re.addr));
        end
      end
      if (done) done_seen++;
    end
  end

  // Host write-ack model: one ack per observed write, one per cycle.
  initial begin
    host_if.wr_rsp_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_seen > acks_sent) begin
        host_if.wr_rsp_valid = 1'b1;
        acks_sent++;
      end else begin
        host_if.wr_rsp_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_job(input logic [AW-1:0] src, input logic [AW-1:0] dst, input logic [TW-1:0] n);
    tick();
    cfg_src_addr  = src;
    cfg_dst_addr  = dst;
    cfg_num_lines = n;
    cfg_start     = 1'b1;
    cur_dst       = dst;
    for (int unsigned i = 0; i < 32'(n); i++)
      rd_exp.push_back('{addr: src + AW'(i), tag: TW'(i)});
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic rsp(input logic [TW-1:0] tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input bit expect_wr);
    host_if.rd_rsp_valid = 1'b1;
    host_if.rd_rsp_tag   = tag;
    host_if.rd_rsp_data  = mk_line(a, b);
    if (expect_wr) wr_exp.push_back('{addr: cur_dst + AW'(tag), data: res_line(r)});
    tick();
  endtask

  task automatic rsp_idle();
    host_if.rd_rsp_valid = 1'b0;
    host_if.rd_rsp_data  = '0;
  endtask

  task automatic wait_reads(input int n, input int base, input int budget, input string name);
    int k;
    k = 0;
    while ((rd_seen - base) < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, LW'(rd_seen - base), LW'(n));
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int k;
    k = 0;
    while (done_seen == d0 && k < budget) begin
      tick();
      k++;
    end
    chk(name, LW'(done_seen - d0), LW'(1));
    chk({name, "_busy"}, LW'(busy), LW'(0));
  endtask

  initial begin
    int base_r, base_w, d0;
    host_if.rd_almost_full = 1'b0;
    host_if.wr_almost_full = 1'b0;
    host_if.rd_rsp_valid   = 1'b0;
    host_if.rd_rsp_tag     = '0;
    host_if.rd_rsp_data    = '0;

    reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", LW'(busy), LW'(0));
    chk("rst_done", LW'(done), LW'(0));
    chk("rst_rd_valid", LW'(host_if.rd_req_valid), LW'(0));
    chk("rst_wr_valid", LW'(host_if.wr_req_valid), LW'(0));
`ifdef ADD_VEC_SATURATE_EN
    chk("rst_sat", LW'(sat_flag), LW'(0));
`endif
    reset_n = 1'b1;
    tick();

    // Single line, every lane 3+5.
    base_r = rd_seen; d0 = done_seen;
    start_job(AW'(42'h100), AW'(42'h200), TW'(1));
    chk("t1_busy", LW'(busy), LW'(1));
    wait_reads(1, base_r, 20, "t1_reads");
    rsp(TW'(0), 32'd3, 32'd5, 32'd8, 1'b1);
    rsp_idle();
    wait_done(d0, 50, "t1_done");

    // Zero-length job: done two cycles after start, no traffic.
    base_r = rd_seen; base_w = wr_seen;
    start_job(AW'(42'h400), AW'(42'h500), TW'(0));
    chk("t2_busy", LW'(busy), LW'(0));
    chk("t2_done_early", LW'(done), LW'(0));
    tick();
    chk("t2_done", LW'(done), LW'(1));
    tick();
    chk("t2_done_end", LW'(done), LW'(0));
    repeat (4) tick();
    chk("t2_no_reads", LW'(rd_seen - base_r), LW'(0));
    chk("t2_no_writes", LW'(wr_seen - base_w), LW'(0));

    // Credit limit: 4 reads then stall; each completed line frees one more read.
    base_r = rd_seen; d0 = done_seen;
    start_job(AW'(42'h1000), AW'(42'h2000), TW'(8));
    repeat (15) tick();
    chk("t3_stall", LW'(rd_seen - base_r), LW'(4));
    for (int k = 0; k < 8; k++) begin
      rsp(TW'(k), 32'(k), 32'h10, 32'(k + 16), 1'b1);
      rsp_idle();
      repeat (8) tick();
      chk("t3_release", LW'(rd_seen - base_r), LW'((k + 5 > 8) ? 8 : k + 5));
    end
    wait_done(d0, 60, "t3_done");

    // Out-of-order responses 3,1,0,2, back to back.
    base_r = rd_seen; d0 = done_seen;
    start_job(AW'(42'h5000), AW'(42'h3000), TW'(4));
    wait_reads(4, base_r, 30, "t4_reads");
    rsp(TW'(3), 32'h0000_0030, 32'h0000_0003, 32'h0000_0033, 1'b1);
    rsp(TW'(1), 32'h0000_0010, 32'h0000_0001, 32'h0000_0011, 1'b1);
    rsp(TW'(0), 32'hA000_0000, 32'h0B00_0000, 32'hAB00_0000, 1'b1);
    rsp(TW'(2), 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
    rsp_idle();
    wait_done(d0, 50, "t4_done");

    // Write back-pressure with a full result FIFO, then a 4-write burst.
    base_r = rd_seen; d0 = done_seen;
    host_if.wr_almost_full = 1'b1;
    start_job(AW'(42'h6000), AW'(42'h7000), TW'(4));
    wait_reads(4, base_r, 30, "t5_reads");
    base_w = wr_seen;
    rsp(TW'(0), 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b1);
    rsp(TW'(1), 32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 1'b1);
    rsp(TW'(2), 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b1);
    rsp(TW'(3), 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b1);
    rsp_idle();
    repeat (20) tick();
    chk("t5_held", LW'(wr_seen - base_w), LW'(0));
    host_if.wr_almost_full = 1'b0;
    repeat (4) tick();
    chk("t5_burst", LW'(wr_seen - base_w), LW'(4));
    wait_done(d0, 50, "t5_done");

    // Lane carry-out.
    base_r = rd_seen; d0 = done_seen;
    start_job(AW'(42'h8000), AW'(42'h9000), TW'(1));
`ifdef ADD_VEC_SATURATE_EN
    chk("t6_sat_clear", LW'(sat_flag), LW'(0));
`endif
    wait_reads(1, base_r, 20, "t6_reads");
    rsp(TW'(0), 32'hFFFF_FFFF, 32'h0000_0002, OVF_RES, 1'b1);
    rsp_idle();
    wait_done(d0, 50, "t6_done");
`ifdef ADD_VEC_SATURATE_EN
    chk("t6_sat_set", LW'(sat_flag), LW'(1));
`endif

    // Reset with two reads in flight; late responses must be dropped.
    base_r = rd_seen;
    start_job(AW'(42'hA000), AW'(42'hB000), TW'(2));
    wait_reads(2, base_r, 20, "t7_reads");
    reset_n = 1'b0;
    tick();
    chk("t7_busy", LW'(busy), LW'(0));
    chk("t7_done", LW'(done), LW'(0));
    chk("t7_rd_valid", LW'(host_if.rd_req_valid), LW'(0));
    chk("t7_wr_valid", LW'(host_if.wr_req_valid), LW'(0));
    reset_n = 1'b1;
    rd_exp.delete();
    base_w = wr_seen; d0 = done_seen;
    rsp(TW'(0), 32'd1, 32'd1, 32'd2, 1'b0);
    rsp(TW'(1), 32'd1, 32'd1, 32'd2, 1'b0);
    rsp_idle();
    repeat (10) tick();
    chk("t7_no_writes", LW'(wr_seen - base_w), LW'(0));
    chk("t7_no_done", LW'(done_seen - d0), LW'(0));
    chk("wr_exp_drained", LW'(wr_exp.size()), LW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/add_vec_engine.md
Name: add_vec_engine

Overview:
- Parametrised successor to the single-line add-two-numbers AFU.
- Streams cfg_num_lines source cache lines; each line is packed as (a,b) operand pairs. The block adds every pair lane-wise and writes one result line per source line to the destination buffer.
- Sits behind the AFU CSR decode, on a flattened CCI-P-style host channel.
- Multiple reads may be in flight; responses may return out of order; write completions are counted before done is raised.

Parameters:
- LINE_W, 512, cache-line data width in bits
- ELEM_W, 32, operand/result width; LINE_W % (2*ELEM_W) == 0
- ADDR_W, 42, cache-line address width
- LEN_W, 16, width of the line count and of the read tag
- MAX_OUTSTANDING, 4, max lines in flight (read issued, result not yet sent to write channel); power of 2, ≥2

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- cfg_start  in  1  one-cycle start pulse; ignored while busy
- cfg_src_addr  in  ADDR_W  source line base
- cfg_dst_addr  in  ADDR_W  destination line base
- cfg_num_lines  in  LEN_W  lines to process
- busy  out  1  job active
- done  out  1  one-cycle pulse at job end
- rd_req_valid  out  1  read request
- rd_req_addr  out  ADDR_W  src + index
- rd_req_tag  out  LEN_W  line index
- rd_almost_full  in  1  read channel back-pressure
- rd_rsp_valid  in  1  read response
- rd_rsp_tag  in  LEN_W  returned index
- rd_rsp_data  in  LINE_W  operand line
- wr_req_valid  out  1  write request
- wr_req_addr  out  ADDR_W  dst + tag
- wr_req_data  out  LINE_W  result line
- wr_almost_full  in  1  write channel back-pressure
- wr_rsp_valid  in  1  write completion

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE.
  - All counters and FIFO cleared.
  - Reset mid-job abandons the job with no done pulse.
- Lanes: NP = LINE_W/(2*ELEM_W).
  - Lane i: a = data[2i*ELEM_W +: ELEM_W], b = next ELEM_W.
  - result[i*ELEM_W +: ELEM_W] = a+b, unsigned, mod 2^ELEM_W.
  - Result bits above NP*ELEM_W are zero.
- Latched at start: src, dst, num_lines.
- IDLE:
  - cfg_start with num_lines==0 → DONE next cycle; no requests issued.
  - cfg_start with num_lines!=0 → RUN; busy=1 from the next cycle.
- RUN:
  - A read is issued in a cycle when issued<num && inflight<MAX_OUTSTANDING && !rd_almost_full.
  - rd_req_* are registered, valid one cycle after the issue decision.
  - Tag = issued; issued increments.
  - inflight = issued − popped.
- Responses:
  - Every rd_rsp_valid in RUN/DRAIN is accepted unconditionally.
  - The sum is computed and pushed to the result FIFO together with the tag, in the same cycle.
  - FIFO depth is MAX_OUTSTANDING; the credit rule guarantees it never overflows.
- Write path:
  - When the FIFO is non-empty and !wr_almost_full, pop the FIFO.
  - wr_req_* are registered next cycle with addr = dst + tag; popped increments.
  - Minimum latency from rd_rsp_valid to wr_req_valid is 2 cycles.
- Transitions:
  - RUN → DRAIN when issued==num.
  - DRAIN → DONE when acked==num, where acked counts wr_rsp_valid.
  - DONE: done=1 for one cycle, busy=0, → IDLE.
- Edge events:
  - Simultaneous response push and write pop in one cycle are both legal.
  - Response or write ack arriving in IDLE is dropped.
  - Tag arithmetic wraps mod 2^ADDR_W.
  - num_lines = 2^LEN_W−1 is legal.

Optional Feature:
- ADD_VEC_SATURATE_EN
- Defined: each lane saturates to 2^ELEM_W−1 on carry-out; a sticky sat_flag output (1 bit, cleared on cfg_start) is added to the ports.
- Undefined: wrap-around add; no sat_flag port.

Decomposition:
- Package add_vec_pkg:
  - t_state enum {IDLE,RUN,DRAIN,DONE}
  - t_tag, t_line typedefs
  - function lane_add(line) → line
- Sub-module add_vec_result_fifo: depth/width-parametrised sync FIFO with push, pop, empty, count.
- Sum logic stays in the package function.

Test Plan:
- Single line, num=1, lanes a=3, b=5 everywhere → one read at tag 0, one write to dst with every lane 8 and upper half 0; done pulses after the ack.
- num=0 → no rd_req_valid or wr_req_valid; done pulses 2 cycles after cfg_start.
- num=8, MAX_OUTSTANDING=4, responses withheld → exactly 4 reads issued, then stall; each returned response plus its write releases one more read.
- num=4, responses returned in tag order 3,1,0,2 → writes go to dst+3, dst+1, dst+0, dst+2 with matching data.
- wr_almost_full held 20 cycles with 4 responses pending → no write requests and no FIFO overflow; on release, 4 back-to-back writes follow.
- Lane a=0xFFFFFFFF, b=2 → result 0x00000001 without ADD_VEC_SATURATE_EN; 0xFFFFFFFF with sat_flag=1 when the macro is defined.
- Also covered: reset asserted mid-job with 2 reads in flight → all outputs 0 next cycle, no done pulse, and late responses ignored.
